// File: rtl/cla_pkg.sv
// Shared helpers and types for the pipelined carry-lookahead adder.
// Provides group count, legal-GROUP check and the per-stage flag bundle.
package cla_pkg;

    function automatic int unsigned cla_groups(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    // Only these group sizes have a balanced lookahead tree in the datapath.
    function automatic bit cla_group_ok(input int unsigned group);
        return (group == 32'd2) || (group == 32'd4) || (group == 32'd8);
    endfunction

    typedef struct packed {
        logic s3;
        logic s2;
        logic s1;
    } stage_bits_t;

endpackage

// File: rtl/cla_group_lookahead.sv
// Group propagate/generate for one GROUP-bit slice of the lookahead adder.
module cla_group_lookahead
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] p_i,
    input  logic [GROUP-1:0] g_i,
    output logic             grp_p_o,
    output logic             grp_g_o
);

    // Gk = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0], folded LSB-first.
    always_comb begin
        grp_p_o = &p_i;
        grp_g_o = 1'b0;
        for (int i = 0; i < int'(GROUP); i++) begin
            grp_g_o = g_i[i] | (p_i[i] & grp_g_o);
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// S1: operand p/g, S2: group carries, S3: in-group carries, sum, cout, overflow.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NG = cla_groups(WIDTH, GROUP);

    if (!cla_group_ok(GROUP) || (WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
        $error("cla_pipe_adder: illegal WIDTH/GROUP combination");
    end

    stage_bits_t v_q;
    logic        en1_c, en2_c, en3_c;

    logic [WIDTH-1:0] p1_d, g1_d, p1_q, g1_q;
    logic             c01_d, c01_q;

    logic [WIDTH-1:0] p2_q, g2_q;
    logic [NG:0]      cg2_d, cg2_q;
    logic [NG-1:0]    grp_p_c, grp_g_c;

    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q;

    // A stage may advance when it is empty or the stage after it advances.
    assign en3_c    = !v_q.s3 | out_ready;
    assign en2_c    = !v_q.s2 | en3_c;
    assign en1_c    = !v_q.s1 | en2_c;
    assign in_ready = en1_c;

    // Subtract is A + ~B + 1; carry-in only matters in add mode.
    always_comb begin
        p1_d  = in_a ^ (in_sub ? ~in_b : in_b);
        g1_d  = in_a & (in_sub ? ~in_b : in_b);
        c01_d = in_sub | in_cin;
    end

    for (genvar k = 0; k < int'(NG); k++) begin : g_grp
        cla_group_lookahead #(
            .GROUP (GROUP)
        ) u_gla (
            .p_i     (p1_q[k*GROUP +: GROUP]),
            .g_i     (g1_q[k*GROUP +: GROUP]),
            .grp_p_o (grp_p_c[k]),
            .grp_g_o (grp_g_c[k])
        );
    end

    // Group carries ripple across groups from the stage-1 carry-in.
    always_comb begin
        logic run;
        cg2_d    = '0;
        run      = c01_q;
        cg2_d[0] = c01_q;
        for (int k = 0; k < int'(NG); k++) begin
            run        = grp_g_c[k] | (grp_p_c[k] & run);
            cg2_d[k+1] = run;
        end
    end

    // Per-bit carries inside each group, seeded from that group's carry.
    always_comb begin
        logic run;
        bit_c = '0;
        run   = 1'b0;
        for (int k = 0; k < int'(NG); k++) begin
            run = cg2_q[k];
            for (int j = 0; j < int'(GROUP); j++) begin
                bit_c[k*GROUP + j] = run;
                run = g2_q[k*GROUP + j] | (p2_q[k*GROUP + j] & run);
            end
        end
        sum_d  = p2_q ^ bit_c;
        cout_d = cg2_q[NG];
        ovf_d  = bit_c[WIDTH-1] ^ cg2_q[NG];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            p1_q   <= '0;
            g1_q   <= '0;
            c01_q  <= 1'b0;
            p2_q   <= '0;
            g2_q   <= '0;
            cg2_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (en1_c) begin
                v_q.s1 <= in_valid;
                p1_q   <= p1_d;
                g1_q   <= g1_d;
                c01_q  <= c01_d;
            end
            if (en2_c) begin
                v_q.s2 <= v_q.s1;
                p2_q   <= p1_q;
                g2_q   <= g1_q;
                cg2_q  <= cg2_d;
            end
            if (en3_c) begin
                v_q.s3 <= v_q.s2;
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v_q.s3;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
